// File: rtl/pwm_capture_if.sv
// pwm_capture_if: capture control inputs and measurement outputs of pwm_capture
// Ports: master drives cap_en, i_pwm, irq_clr; slave drives period_meas, high_meas, cap_valid, cap_irq, cap_ovf.
interface pwm_capture_if #(
  parameter int CNT_W = 16
);
  logic             cap_en;
  logic             i_pwm;
  logic             irq_clr;
  logic [CNT_W-1:0] period_meas;
  logic [CNT_W-1:0] high_meas;
  logic             cap_valid;
  logic             cap_irq;
  logic             cap_ovf;
  modport master (
    output cap_en, i_pwm, irq_clr,
    input  period_meas, high_meas, cap_valid, cap_irq, cap_ovf
  );
  modport slave (
    input  cap_en, i_pwm, irq_clr,
    output period_meas, high_meas, cap_valid, cap_irq, cap_ovf
  );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input in chosen_clk cycles
// Ports: chosen_clk clock, rst_n async active-low reset, io_cap slave bundle
//   (in: cap_en, i_pwm, irq_clr; out: period_meas, high_meas, cap_valid, cap_irq, cap_ovf).
// Define PWM_CAP_FILTER_EN to insert a 3-sample stability filter after the synchronizer.
module pwm_capture #(
  parameter int CNT_W = 16
) (
  input logic          chosen_clk,
  input logic          rst_n,
  pwm_capture_if.slave io_cap
);
  localparam logic [1:0] IDLE = 2'd0, ARM = 2'd1, HIGH = 2'd2, LOW = 2'd3;
  localparam logic [CNT_W-1:0] MAX = '1;
  logic [1:0] r_state, w_next;
  logic r_s1, r_s2, r_pf_d, w_pf, w_rise, w_fall, w_en, w_max;
  logic w_start, w_pub, w_tout, w_hcap;
  logic [CNT_W-1:0] r_cnt, r_high_cap, r_period, r_high;
  logic r_valid, r_irq, r_ovf;
  assign w_en = io_cap.cap_en;
  always_ff @(posedge chosen_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_pf_d <= 1'b0;
    end else begin
      r_s1   <= io_cap.i_pwm;
      r_s2   <= r_s1;
      r_pf_d <= w_pf;
    end
  end
`ifdef PWM_CAP_FILTER_EN
  logic [1:0] r_sh;
  logic       r_pf;
  // pf takes the new level in the third consecutive cycle s2 holds it, so both edges see the same delay
  assign w_pf = (r_s2 == r_sh[0] && r_s2 == r_sh[1]) ? r_s2 : r_pf;
  always_ff @(posedge chosen_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh <= 2'b00;
      r_pf <= 1'b0;
    end else begin
      r_sh <= {r_sh[0], r_s2};
      r_pf <= w_pf;
    end
  end
`else
  assign w_pf = r_s2;
`endif
  assign w_rise = w_pf & ~r_pf_d;
  assign w_fall = ~w_pf & r_pf_d;
  assign w_max  = r_cnt == MAX;
  always_ff @(posedge chosen_clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  // A phase that reaches MAX is unmeasurable; in HIGH the timeout beats a coincident fall so high < period holds
  always_comb begin
    w_next = !w_en ? IDLE :
             r_state == IDLE ? ARM :
             r_state == ARM ? (w_rise ? HIGH : ARM) :
             w_tout ? ARM :
             r_state == HIGH ? (w_fall ? LOW : HIGH) :
             (w_rise ? HIGH : LOW);
  end
  always_comb begin
    w_start = w_en && r_state == ARM && w_rise;
    w_pub   = w_en && r_state == LOW && w_rise;
    w_tout  = w_en && w_max && (r_state == HIGH || (r_state == LOW && !w_rise));
    w_hcap  = w_en && r_state == HIGH && w_fall && !w_max;
  end
  always_ff @(posedge chosen_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_high_cap <= '0;
      r_period   <= '0;
      r_high     <= '0;
      r_valid    <= 1'b0;
      r_irq      <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_cnt      <= (w_start || w_pub) ? CNT_W'(1) :
                    (w_next == HIGH || w_next == LOW) ? r_cnt + 1'b1 : '0;
      r_high_cap <= w_hcap ? r_cnt : r_high_cap;
      r_period   <= w_pub ? r_cnt : r_period;
      r_high     <= w_pub ? r_high_cap : r_high;
      r_valid    <= w_pub;
      r_irq      <= w_pub | (r_irq & ~io_cap.irq_clr);
      r_ovf      <= w_tout | (r_ovf & ~io_cap.irq_clr);
    end
  end
  assign io_cap.period_meas = r_period;
  assign io_cap.high_meas   = r_high;
  assign io_cap.cap_valid   = r_valid;
  assign io_cap.cap_irq     = r_irq;
  assign io_cap.cap_ovf     = r_ovf;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed scoreboard bench for pwm_capture
module tb_pwm_capture;
`ifdef PWM_CAP_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  typedef struct {int p; int h; bit c;} exp_t;
  logic clk, rst_n;
  int n_pass, n_total, ncyc, last_v, exp_p, exp_h, k;
  bit have_prev, chained;
  exp_t q[$];
  exp_t e;
  pwm_capture_if #(.CNT_W(16)) io ();
  pwm_capture #(.CNT_W(16)) dut (.chosen_clk(clk), .rst_n(rst_n), .io_cap(io.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic rise();
    if (have_prev) begin
      q.push_back('{exp_p, exp_h, chained});
      chained = 1;
    end else chained = 0;
    have_prev = 1;
    io.i_pwm = 1'b1;
  endtask
  task automatic cyc(input int h, input int l);
    rise();
    exp_p = h + l;
    exp_h = h;
    repeat (h) @(negedge clk);
    io.i_pwm = 1'b0;
    repeat (l) @(negedge clk);
  endtask
  always @(negedge clk) begin
    ncyc++;
    if (rst_n && io.cap_valid) begin
      if (q.size() == 0) check("spurious_valid", io.cap_valid, 1'b0);
      else begin
        e = q.pop_front();
        check("period_meas", io.period_meas, e.p);
        check("high_meas", io.high_meas, e.h);
        if (e.c) check("valid_interval", ncyc - last_v, e.p);
      end
      last_v = ncyc;
    end
  end
  initial begin
    rst_n = 1'b0;
    io.cap_en = 1'b0;
    io.i_pwm = 1'b0;
    io.irq_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_period", io.period_meas, 0);
    check("rst_high", io.high_meas, 0);
    check("rst_valid", io.cap_valid, 0);
    check("rst_irq", io.cap_irq, 0);
    check("rst_ovf", io.cap_ovf, 0);
    rst_n = 1'b1;
    io.cap_en = 1'b1;
    repeat (3) @(negedge clk);
    repeat (6) cyc(3, 7);
    check("basic_drain", q.size(), 0);
    check("basic_period", io.period_meas, 10);
    check("basic_high", io.high_meas, 3);
    check("basic_irq", io.cap_irq, 1);
    check("basic_ovf", io.cap_ovf, 0);
    rise();
    exp_p = 10;
    exp_h = 6;
    repeat (LAT) @(negedge clk);
    io.irq_clr = 1'b1;
    @(negedge clk);
    io.irq_clr = 1'b0;
    check("prio_valid", io.cap_valid, 1);
    check("prio_irq", io.cap_irq, 1);
    repeat (6 - LAT - 1) @(negedge clk);
    io.i_pwm = 1'b0;
    repeat (4) @(negedge clk);
    cyc(3, 7);
    rise();
    repeat (LAT + 2) @(negedge clk);
    io.cap_en = 1'b0;
    have_prev = 0;
    @(negedge clk);
    io.cap_en = 1'b1;
    repeat (8 - LAT - 3) @(negedge clk);
    io.i_pwm = 1'b0;
    repeat (7) @(negedge clk);
    cyc(3, 7);
    cyc(3, 7);
    check("en_drain", q.size(), 0);
    check("en_period", io.period_meas, 10);
    check("en_high", io.high_meas, 3);
    check("pre_ovf", io.cap_ovf, 0);
    have_prev = 0;
    k = 0;
    while (!io.cap_ovf && k < 70000) begin
      @(negedge clk);
      k++;
    end
    check("ovf_set", io.cap_ovf, 1);
    check("ovf_latency", k, 65526 + LAT);
    check("ovf_period", io.period_meas, 10);
    check("ovf_irq", io.cap_irq, 1);
    io.irq_clr = 1'b1;
    @(negedge clk);
    io.irq_clr = 1'b0;
    check("clr_irq", io.cap_irq, 0);
    check("clr_ovf", io.cap_ovf, 0);
    cyc(3, 7);
    rise();
    repeat (3) @(negedge clk);
    io.i_pwm = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_drain", q.size(), 0);
    check("pre_rst_irq", io.cap_irq, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_period", io.period_meas, 0);
    check("mid_rst_high", io.high_meas, 0);
    check("mid_rst_valid", io.cap_valid, 0);
    check("mid_rst_irq", io.cap_irq, 0);
    check("mid_rst_ovf", io.cap_ovf, 0);
    have_prev = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
`ifdef PWM_CAP_FILTER_EN
    repeat (4) begin
      rise();
      exp_p = 20;
      exp_h = 8;
      repeat (8) @(negedge clk);
      io.i_pwm = 1'b0;
      repeat (3) @(negedge clk);
      io.i_pwm = 1'b1;
      @(negedge clk);
      io.i_pwm = 1'b0;
      repeat (3) @(negedge clk);
      io.i_pwm = 1'b1;
      repeat (2) @(negedge clk);
      io.i_pwm = 1'b0;
      repeat (3) @(negedge clk);
    end
    check("filt_period", io.period_meas, 20);
    check("filt_high", io.high_meas, 8);
`else
    repeat (6) cyc(1, 1);
    repeat (4) @(negedge clk);
    check("fast_period", io.period_meas, 2);
    check("fast_high", io.high_meas, 1);
`endif
    repeat (8) @(negedge clk);
    check("final_drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pwm_capture.md
# pwm_capture

PWM input-capture block: the receiving end of the timer's PWM output. It samples an external PWM waveform on `chosen_clk` and measures its period and high time in clock cycles. It publishes each complete measurement with a valid pulse and a sticky interrupt flag. It sits beside the PWM generator in the timer core and feeds the Wishbone register file with read-only capture values.

## Interface
- `CNT_W`, 16: width of the cycle counter and of the measurement outputs.
- `chosen_clk`  input  1  active-high clock; the same selected clock that drives the main counter.
- `rst_n`  input  1  asynchronous, active-low reset.
- `cap_en`  input  1  capture enable; when low the block sits in IDLE.
- `i_pwm`  input  1  external PWM waveform; asynchronous to `chosen_clk`.
- `irq_clr`  input  1  one-cycle pulse that clears `cap_irq` and `cap_ovf`.
- `period_meas`  output  CNT_W  last captured period, in cycles.
- `high_meas`  output  CNT_W  last captured high time, in cycles.
- `cap_valid`  output  1  one-cycle pulse when both measurement outputs have just been updated.
- `cap_irq`  output  1  sticky capture-done flag.
- `cap_ovf`  output  1  sticky flag: no edge was seen for 2^CNT_W−1 cycles.

## Operation
- **Input path**
  - `i_pwm` passes through a 2-flop synchronizer giving `s2`, then an optional filter (see Configuration) giving `pf`.
  - One more flop `pf_d` drives edge detection: `rise = pf & ~pf_d`, `fall = ~pf & pf_d`.
- **States**
  - IDLE: counter held at 0. If `cap_en`=1 → ARM.
  - ARM: waits for the first `rise` and discards any partial period. On `rise`: `cnt`←1, → HIGH.
  - HIGH: `cnt` increments. On `fall`: `high_cap`←`cnt`, → LOW.
  - LOW: `cnt` increments. On `rise`: `period_meas`←`cnt`, `high_meas`←`high_cap`, `cap_valid`=1, `cap_irq`←1, `cnt`←1, → HIGH.
- **Counting rule**
  - `cnt` equals the number of cycles since the last rise-detect cycle.
  - A waveform with period P and high time H therefore reads exactly `period_meas`=P and `high_meas`=H.
- **Timeout**
  - In HIGH or LOW, if `cnt` reaches 2^CNT_W−1 with no qualifying edge: `cap_ovf`←1, `cnt`←0, → ARM.
  - No capture is published on timeout.
  - This covers 0 % and 100 % duty inputs.
- **`cap_en` deassert**
  - Any state → IDLE on the next edge; `cnt`←0.
  - `period_meas` and `high_meas` retain their values; `cap_irq` and `cap_ovf` retain their values.
- **Flag priority**
  - `irq_clr` clears `cap_irq` and `cap_ovf`.
  - If a set event and `irq_clr` occur in the same cycle, the set wins.
- **Width rules**
  - `cnt` is unsigned CNT_W bits and never wraps; the timeout fires first.
  - `high_meas` < `period_meas` always holds for a published capture.

## Timing
- **Reset values:** `rst_n` low asynchronously forces all of the following to 0: state=IDLE, synchronizer and filter flops, `cnt`, `period_meas`, `high_meas`, `cap_valid`, `cap_irq`, `cap_ovf`.
- **Pin-to-detect latency:** 3 cycles without the filter (2 synchronizer flops + edge flop); 5 cycles with it. The latency is identical for both edge types, so measurements are unaffected.
- **Publish timing:** `period_meas`, `high_meas` and `cap_irq` update on the clock edge ending the rise-detect cycle in LOW. `cap_valid` is high for exactly that following cycle.
- **First capture:** the first valid capture arrives one full input period after the first rise-detect in ARM.
- **Minimum measurable pulse:**
  - High or low phase ≥1 cycle without the filter.
  - ≥3 cycles with the filter; shorter pulses are absorbed.
- **Reset mid-operation:** the capture in progress is lost. After release the block restarts from IDLE/ARM; no stale `cap_valid` is produced.

## Configuration
- **Macro:** `PWM_CAP_FILTER_EN`.
- **Defined:** a 3-sample stability filter sits between `s2` and `pf`. `pf` changes only after `s2` has held the new level for 3 consecutive cycles. Glitches of 1–2 cycles are rejected. Adds 2 cycles of latency.
- **Undefined:** `pf` = `s2` directly; no added latency.

## Test plan
- **Basic capture:** `cap_en`=1; `i_pwm` with period 10 cycles and high time 3 cycles, applied for 5 periods. Required: `period_meas`=10, `high_meas`=3, and `cap_valid` pulses every 10 cycles starting one period after the first detected rise.
- **Timeout:** after one valid capture, hold `i_pwm`=0. Required: `cap_ovf`=1 after 65535 cycles, `period_meas` still 10, no `cap_valid`.
- **Flag priority:** assert `irq_clr` in the same cycle as a `cap_valid`. Required: `cap_irq` stays 1. A lone `irq_clr` later clears `cap_irq` and `cap_ovf` to 0.
- **Enable and reset mid-period:** drop `cap_en` mid-HIGH, then re-raise it. Required: no capture from the partial period; the next capture is correct (10/3). Separately, pulse `rst_n` low mid-LOW. Required: all outputs 0 immediately.
- **Filter (`PWM_CAP_FILTER_EN` defined):** inject 1-cycle and 2-cycle high glitches during the low phase of a 20/8 waveform. Required: `period_meas`=20, `high_meas`=8, no spurious capture.
- **Without filter:** a 1-high/1-low waveform (period 2). Required: `period_meas`=2, `high_meas`=1.
